obstacle_map_writer: RTL and testbench

OBSTACLE_MAP_WRITER -- requirements
Module: obstacle_map_writer

---
 rtl/obstacle_map_writer.sv | 122 ++++++++++++
 tb/tb_obstacle_map_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_map_writer.sv
// Builds a square obstacle bitmap in an external RAM: clears every row, then
// read-modify-writes one bit per accepted (x,y) pair until the collector finishes.
module obstacle_map_writer #(
  parameter int GRID_BITS = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    coord_x,
  input  logic [7:0]                    coord_y,
  input  logic                          coord_valid,
  output logic                          coord_ready,
  input  logic                          finish_in,
  input  logic                          restart,
  output logic [GRID_BITS-1:0]          mem_addr,
  output logic                          mem_rden,
  input  logic [(1<<GRID_BITS)-1:0]     mem_rdata,
  output logic                          mem_wren,
  output logic [(1<<GRID_BITS)-1:0]     mem_wdata,
  output logic [2*GRID_BITS:0]          obstacle_count,
  output logic [7:0]                    oob_count,
  output logic                          err_oob,
  output logic                          map_ready
);

  localparam int SIDE = 1 << GRID_BITS;
  localparam int CW   = 2*GRID_BITS + 1;

  typedef enum logic [2:0] {CLEAR, IDLE, READ, MERGE, DONE} state_t;

  state_t               state, state_nxt;
  logic [GRID_BITS-1:0] row_cnt, x_lat, y_lat;
  logic [SIDE-1:0]      x_bit;
  logic                 accept, in_range;

  assign accept   = coord_valid && (state == IDLE);
  assign in_range = ((coord_x >> GRID_BITS) == 8'd0) && ((coord_y >> GRID_BITS) == 8'd0);
  assign x_bit    = {{(SIDE-1){1'b0}}, 1'b1} << x_lat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  // RAM strobes are gated by reset so a read/merge in flight is dropped the
  // moment reset asserts, rather than waiting for the next clock edge.
  always_comb begin
    state_nxt   = state;
    coord_ready = 1'b0;
    map_ready   = 1'b0;
    mem_addr    = y_lat;
    mem_wdata   = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    case (state)
      CLEAR: begin
        mem_addr = row_cnt;
        mem_wren = reset;
        if (&row_cnt) state_nxt = IDLE;
      end
      IDLE: begin
        coord_ready = 1'b1;
        if (accept) begin
          if (in_range) state_nxt = READ;
        end else if (finish_in) begin
          state_nxt = DONE;
        end
      end
      READ: begin
        mem_rden  = reset;
        state_nxt = MERGE;
      end
      MERGE: begin
        mem_wren  = reset;
        mem_wdata = mem_rdata | x_bit;
        state_nxt = IDLE;
      end
      DONE: begin
        map_ready = 1'b1;
        if (restart) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt        <= '0;
      x_lat          <= '0;
      y_lat          <= '0;
      obstacle_count <= '0;
      oob_count      <= '0;
      err_oob        <= 1'b0;
    end else begin
      err_oob <= 1'b0;
      case (state)
        CLEAR: row_cnt <= row_cnt + GRID_BITS'(1);
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              x_lat <= coord_x[GRID_BITS-1:0];
              y_lat <= coord_y[GRID_BITS-1:0];
            end else begin
              err_oob <= 1'b1;
              if (oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
            end
          end
        end
        // Only a newly set cell counts, so the total is bounded by the grid area.
        MERGE: if (!mem_rdata[x_lat]) obstacle_count <= obstacle_count + CW'(1);
        DONE: begin
          if (restart) begin
            obstacle_count <= '0;
            oob_count      <= '0;
            row_cnt        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_map_writer.sv
// Directed + randomized bench for obstacle_map_writer with a RAM model and a
// cell-set reference model of the obstacle map.
module tb_obstacle_map_writer;
  localparam int GB   = 5;
  localparam int SIDE = 1 << GB;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      coord_x = '0, coord_y = '0;
  logic            coord_valid = 1'b0, finish_in = 1'b0, restart = 1'b0;
  logic            coord_ready, mem_rden, mem_wren, err_oob, map_ready;
  logic [GB-1:0]   mem_addr;
  logic [SIDE-1:0] mem_rdata = '0, mem_wdata;
  logic [2*GB:0]   obstacle_count;
  logic [7:0]      oob_count;

  obstacle_map_writer #(.GRID_BITS(GB)) dut (
    .clk(clk), .reset(reset), .coord_x(coord_x), .coord_y(coord_y),
    .coord_valid(coord_valid), .coord_ready(coord_ready), .finish_in(finish_in),
    .restart(restart), .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_rdata(mem_rdata),
    .mem_wren(mem_wren), .mem_wdata(mem_wdata), .obstacle_count(obstacle_count),
    .oob_count(oob_count), .err_oob(err_oob), .map_ready(map_ready)
  );

  always #5 clk = ~clk;

  logic [SIDE-1:0] ram [SIDE];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    if (mem_rden) mem_rdata <= ram[mem_addr];
  end

  int checks = 0, failures = 0;
  bit ref_cell [SIDE][SIDE];   // [y][x]
  int ref_count = 0, ref_oob = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SIDE-1:0] ref_row(input int y);
    logic [SIDE-1:0] r;
    for (int x = 0; x < SIDE; x++) r[x] = ref_cell[y][x];
    return r;
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic send(input int x, input int y);
    logic [SIDE-1:0] exp_row;
    coord_x = x[7:0]; coord_y = y[7:0]; coord_valid = 1'b1;
    chk("ready_pre", coord_ready, 1);
    step;
    coord_valid = 1'b0;
    if (x < SIDE && y < SIDE) begin
      chk("rd_strobe", mem_rden, 1);
      chk("rd_addr", mem_addr, y);
      chk("rd_nowr", mem_wren, 0);
      step;
      exp_row = ref_row(y);
      exp_row[x] = 1'b1;
      chk("mg_wren", mem_wren, 1);
      chk("mg_nord", mem_rden, 0);
      chk("mg_addr", mem_addr, y);
      chk("mg_wdata", mem_wdata, exp_row);
      if (!ref_cell[y][x]) ref_count++;
      ref_cell[y][x] = 1'b1;
      step;
      chk("back_idle", coord_ready, 1);
      chk("obs_count", obstacle_count, ref_count);
    end else begin
      chk("oob_pulse", err_oob, 1);
      chk("oob_nowr", mem_wren, 0);
      chk("oob_nord", mem_rden, 0);
      chk("oob_ready", coord_ready, 1);
      if (ref_oob < 255) ref_oob++;
      chk("oob_cnt", oob_count, ref_oob);
      step;
      chk("oob_pulse_end", err_oob, 0);
    end
  endtask

  task automatic run_clear;
    chk("clr_wren0", mem_wren, 1);
    chk("clr_addr0", mem_addr, 0);
    chk("clr_wdata0", mem_wdata, 0);
    for (int i = 1; i < SIDE; i++) begin
      step;
      chk("clr_wren", mem_wren, 1);
      chk("clr_addr", mem_addr, i);
      chk("clr_ready", coord_ready, 0);
    end
    step;
    chk("clr_done_ready", coord_ready, 1);
    chk("clr_done_wren", mem_wren, 0);
  endtask

  task automatic clear_model;
    for (int y = 0; y < SIDE; y++)
      for (int x = 0; x < SIDE; x++) ref_cell[y][x] = 1'b0;
    ref_count = 0;
    ref_oob = 0;
  endtask

  initial begin
    logic [SIDE-1:0] exp_row;
    clear_model();
    // reset state
    step; step;
    chk("rst_ready", coord_ready, 0);
    chk("rst_map_ready", map_ready, 0);
    chk("rst_obs", obstacle_count, 0);
    chk("rst_oob", oob_count, 0);
    chk("rst_err", err_oob, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_rden", mem_rden, 0);
    reset = 1'b1; #1;
    run_clear();

    // directed pairs
    send(3, 5);
    send(3, 5);
    send(4, 5);
    chk("row5", ram[5], 32'h18);
    chk("row5_count", obstacle_count, 2);
    send(40, 2);

    // restart outside DONE is ignored
    restart = 1'b1; step; restart = 1'b0;
    chk("rs_ign_ready", coord_ready, 1);
    chk("rs_ign_wren", mem_wren, 0);
    chk("rs_ign_count", obstacle_count, ref_count);

    // randomized pairs, mixed in-range/out-of-range with duplicates
    repeat (60) begin
      int x, y;
      x = $urandom_range(0, 39);
      y = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) y = $urandom_range(32, 255);
      send(x, y);
    end

    // oob saturation
    coord_x = 8'd200; coord_y = 8'd1; coord_valid = 1'b1;
    repeat (300) step;
    coord_valid = 1'b0;
    ref_oob = (ref_oob + 300 > 255) ? 255 : ref_oob + 300;
    chk("oob_sat", oob_count, ref_oob);
    chk("oob_sat_err", err_oob, 1);
    step;
    chk("oob_sat_err_end", err_oob, 0);
    chk("oob_sat_hold", oob_count, 255);

    // pair and finish in the same cycle
    coord_x = 8'd1; coord_y = 8'd1; coord_valid = 1'b1; finish_in = 1'b1;
    step;
    coord_valid = 1'b0;
    chk("fin_rd", mem_rden, 1);
    chk("fin_rd_addr", mem_addr, 1);
    step;
    exp_row = ref_row(1);
    exp_row[1] = 1'b1;
    chk("fin_wr", mem_wren, 1);
    chk("fin_wdata", mem_wdata, exp_row);
    if (!ref_cell[1][1]) ref_count++;
    ref_cell[1][1] = 1'b1;
    step;
    chk("fin_t3_map", map_ready, 0);
    chk("fin_t3_ready", coord_ready, 1);
    step;
    chk("fin_t4_map", map_ready, 1);
    chk("fin_t4_ready", coord_ready, 0);
    finish_in = 1'b0;

    // DONE holds and ignores pairs
    coord_x = 8'd2; coord_y = 8'd2; coord_valid = 1'b1;
    repeat (3) begin
      step;
      chk("done_map", map_ready, 1);
      chk("done_rden", mem_rden, 0);
      chk("done_wren", mem_wren, 0);
      chk("done_obs", obstacle_count, ref_count);
      chk("done_oob", oob_count, ref_oob);
    end
    coord_valid = 1'b0;
    for (int y = 0; y < SIDE; y++) chk("map_row", ram[y], ref_row(y));

    // restart rebuilds from scratch
    restart = 1'b1; step; restart = 1'b0;
    chk("rs_map", map_ready, 0);
    chk("rs_obs", obstacle_count, 0);
    chk("rs_oob", oob_count, 0);
    run_clear();
    clear_model();
    for (int y = 0; y < SIDE; y++) chk("rs_row_zero", ram[y], 0);

    // reset during MERGE drops the write
    coord_x = 8'd7; coord_y = 8'd3; coord_valid = 1'b1;
    step;
    coord_valid = 1'b0;
    step;
    chk("mr_wren_pre", mem_wren, 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_wren_rst", mem_wren, 0);
    chk("mr_rden_rst", mem_rden, 0);
    chk("mr_ready_rst", coord_ready, 0);
    step; step;
    chk("mr_wren_hold", mem_wren, 0);
    chk("mr_row3", ram[3], 0);
    reset = 1'b1; #1;
    run_clear();
    chk("mr_obs", obstacle_count, 0);

    // finish alone goes straight to DONE
    finish_in = 1'b1;
    step;
    chk("fin_only_map", map_ready, 1);
    chk("fin_only_ready", coord_ready, 0);
    finish_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
